mux_n_1_rr_stream: RTL and testbench
====================================

Name: mux_n_1_rr_stream

Overview:
- Parametrised N:1 stream multiplexer with valid/ready handshake on every channel and one registered output stage.
- Two selection modes:
  - fixed mode: software-selected channel, the direct successor of the 4:1 select mux.
  - round-robin mode: fair arbitration across all requesting channels.
- Sits between N producer streams and a single consumer; out_sel tags each beat with its source channel.

Parameters:
- WIDTH, 4, data width per channel in bits.
- N, 4, number of input channels; N >= 2.
- SEL_W, $clog2(N), channel index width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- fixed_sel  input  SEL_W  channel used in fixed mode.
- in_valid  input  N  per-channel valid.
- in_data  input  N*WIDTH  flattened data; channel i at bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready (combinational).
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_sel  output  SEL_W  source channel of the held beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - out_valid = 0, out_data = 0, out_sel = 0, rr pointer ptr = 0.
  - Any beat in flight is discarded.
  - in_ready = 0 during reset.
- Slot free: accept = !out_valid || out_ready. This is a single-entry pipeline register with full-throughput back-to-back transfers.
- Grant (combinational, one-hot or zero):
  - mode = 0: grant[fixed_sel] = in_valid[fixed_sel]. No grant if fixed_sel >= N.
  - mode = 1: grant goes to the first i with in_valid[i] = 1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
- in_ready[i] = accept && grant[i]. At most one in_ready bit is high.
- Transfer on input i when in_valid[i] && in_ready[i]. At the next edge: out_valid = 1, out_data = channel i data, out_sel = i.
- Output consumed (out_valid && out_ready) with no new transfer in the same cycle: out_valid = 0 at the next edge. out_data and out_sel hold their values (not cleared).
- Consume and load in the same cycle: the register takes the new beat; out_valid stays 1.
- Stall (out_valid && !out_ready):
  - out_data and out_sel held stable.
  - All in_ready = 0.
  - ptr unchanged.
- Latency: input transfer to out_valid = 1 cycle.
- ptr update:
  - Only on a transfer in mode 1: ptr = (i == N-1) ? 0 : i+1.
  - Unchanged in mode 0 and on cycles with no transfer.
- Mode or fixed_sel change:
  - Affects grant from the same cycle (combinational).
  - Never alters a beat already in the output register.
  - ptr is retained across mode switches.
- Protocol: producers must hold in_valid and in_data stable until accepted. in_valid may deassert without consequence when no transfer occurs.
- Non-power-of-two N is supported: pointer wraps at N-1, not at 2^SEL_W - 1.
- X on in_data of an ungranted channel must not reach out_data.

Test Plan (WIDTH = 4, N = 4):
- Fixed select:
  - Stimulus: mode 0, in_data = {d,c,b,a} (ch3..ch0), all valid, out_ready = 1, fixed_sel stepping 0..3.
  - Response: out_data a, b, c, d with out_sel 0..3, each one cycle after its select; only in_ready[fixed_sel] high.
- Round-robin, all requesting:
  - Stimulus: mode 1, all four valid continuously, out_ready = 1, from reset.
  - Response: out_sel sequence 0, 1, 2, 3, 0, 1; one beat per cycle.
- Round-robin skip and wrap:
  - Stimulus: mode 1, only ch1 and ch3 valid.
  - Response: out_sel 1, 3, 1, 3; no gaps.
- Backpressure:
  - Stimulus: out_ready = 0 for 3 cycles after the first beat 'hA from ch0.
  - Response: out_valid = 1 and out_data = 'hA held; in_ready = 0000. After out_ready rises, the next beat follows without a bubble.
- Fixed select out of range:
  - Stimulus: N = 3 build, mode 0, fixed_sel = 3, all valid.
  - Response: in_ready = 000; out_valid stays 0.
- Reset mid-operation:
  - Stimulus: assert rst while out_valid = 1 and ptr = 2.
  - Response: next edge gives out_valid = 0, out_data = 0, out_sel = 0. First round-robin grant after reset goes to ch0 with all channels valid.

Source files
------------

// File: rtl/mux_n_1_rr_stream_if.sv
// Stream bundle for mux_n_1_rr_stream.
//   in_valid  [N]        per-channel valid from the producers
//   in_data   [N*WIDTH]  flattened producer data, channel i at [i*WIDTH +: WIDTH]
//   in_ready  [N]        per-channel ready back to the producers
//   out_valid            output register holds a beat
//   out_data  [WIDTH]    held beat
//   out_sel   [SEL_W]    source channel of the held beat
//   out_ready            consumer accepts the held beat
// master: producer/consumer side. slave: the multiplexer.
interface mux_n_1_rr_stream_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 4
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );
endinterface

// File: rtl/mux_n_1_rr_stream.sv
// N:1 stream multiplexer with a single registered output stage.
// mode = 0 selects channel fixed_sel; mode = 1 arbitrates round-robin starting at ptr.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   fixed_sel  channel used in fixed mode (values >= N grant nothing)
//   bus        stream bundle (slave view): N inputs, one registered output with out_sel tag
module mux_n_1_rr_stream #(
    parameter int unsigned  WIDTH = 4,
    parameter int unsigned  N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] fixed_sel,
    mux_n_1_rr_stream_if.slave bus
);

    logic [WIDTH-1:0] ch_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             accept;
    logic             xfer;

    // Grant as an index plus valid; the one-hot form only appears on in_ready.
    always_comb begin : grant_logic
        int unsigned idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!mode) begin
            if (32'(fixed_sel) < N && bus.in_valid[fixed_sel]) begin
                grant_vld = 1'b1;
                grant_idx = fixed_sel;
            end
        end else begin
            // Scan ptr, ptr+1, ... wrapping at N (not at 2^SEL_W); first hit wins.
            for (int unsigned off = 0; off < N; off++) begin
                idx = 32'(ptr_q) + off;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_vld && bus.in_valid[SEL_W'(idx)]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    assign accept = !out_valid_q || bus.out_ready;
    assign xfer   = accept && grant_vld && !rst;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            // Only the granted channel's data is ever selected.
            out_data_d  = ch_data[grant_idx];
            out_sel_d   = grant_idx;
            if (mode) begin
                ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            // Consumed with nothing new: drop valid, keep data/sel.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_n_1_rr_stream.sv
module tb_mux_n_1_rr_stream;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       mode;
    logic [1:0] fixed_sel;
    logic       rst3;
    logic       mode3;
    logic [1:0] sel3;

    mux_n_1_rr_stream_if #(.WIDTH(4), .N(4)) bus4 ();
    mux_n_1_rr_stream_if #(.WIDTH(4), .N(3)) bus3 ();

    mux_n_1_rr_stream #(.WIDTH(4), .N(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .fixed_sel (fixed_sel),
        .bus       (bus4)
    );

    mux_n_1_rr_stream #(.WIDTH(4), .N(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst3),
        .mode      (mode3),
        .fixed_sel (sel3),
        .bus       (bus3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state for the N=4 instance.
    bit         m_known = 1'b0;
    logic       m_valid = 1'b0;
    logic [3:0] m_data  = 4'h0;
    int         m_sel   = 0;
    int         m_ptr   = 0;
    logic [3:0] exp_ready = 4'h0;
    int         q_sel[$];
    logic [3:0] q_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the N=4 instance: check at negedge, advance model, return at posedge+1.
    task automatic cycle();
        int   g;
        logic acc;
        @(negedge clk);
        g = -1;
        if (!mode) begin
            if (int'(fixed_sel) < N && bus4.in_valid[fixed_sel]) g = int'(fixed_sel);
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && bus4.in_valid[c]) g = c;
            end
        end
        acc = !m_valid || bus4.out_ready;
        exp_ready = (!rst && acc && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("in_ready", 32'(bus4.in_ready), 32'(exp_ready));
        if (m_known) begin
            chk("out_valid", 32'(bus4.out_valid), 32'(m_valid));
            chk("out_data", 32'(bus4.out_data), 32'(m_data));
            chk("out_sel", 32'(bus4.out_sel), 32'(m_sel));
            if (bus4.out_valid === 1'b1 && bus4.out_ready) begin
                q_sel.push_back(int'(bus4.out_sel));
                q_data.push_back(bus4.out_data);
            end
        end
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 4'h0;
            m_sel   = 0;
            m_ptr   = 0;
            m_known = 1'b1;
        end else if (exp_ready != 4'b0) begin
            m_valid = 1'b1;
            m_data  = 4'(bus4.in_data >> (4 * g));
            m_sel   = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (bus4.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int exp_sel_a[4];
        int exp_sel_b[6];
        rst = 1'b1; mode = 1'b0; fixed_sel = 2'd0;
        bus4.in_valid = '0; bus4.in_data = '0; bus4.out_ready = 1'b0;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0;
        bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b0;

        // Reset state (checked by the model on the following cycle).
        cycle();
        cycle();
        rst = 1'b0;

        // Fixed select stepping 0..3.
        mode = 1'b0; bus4.in_valid = 4'hF; bus4.in_data = 16'hDCBA; bus4.out_ready = 1'b1;
        q_sel.delete(); q_data.delete();
        for (int s = 0; s < 4; s++) begin
            fixed_sel = 2'(s);
            cycle();
        end
        cycle();
        chk("fix_beats", 32'(q_sel.size()), 32'd4);
        exp_sel_a = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++) begin
            chk("fix_sel", 32'(q_sel[i]), 32'(exp_sel_a[i]));
            chk("fix_data", 32'(q_data[i]), 32'(4'hA + 4'(i)));
        end

        // Round-robin, all requesting, from reset.
        do_reset();
        mode = 1'b1; bus4.in_valid = 4'hF; bus4.in_data = 16'h4321;
        q_sel.delete(); q_data.delete();
        repeat (7) cycle();
        chk("rr_beats", 32'(q_sel.size()), 32'd6);
        exp_sel_b = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) chk("rr_sel", 32'(q_sel[i]), 32'(exp_sel_b[i]));

        // Round-robin skip and wrap: only ch1 and ch3.
        do_reset();
        mode = 1'b1; bus4.in_valid = 4'b1010; bus4.in_data = 16'h7050;
        q_sel.delete(); q_data.delete();
        repeat (5) cycle();
        chk("skip_beats", 32'(q_sel.size()), 32'd4);
        exp_sel_a = '{1, 3, 1, 3};
        for (int i = 0; i < 4; i++) chk("skip_sel", 32'(q_sel[i]), 32'(exp_sel_a[i]));

        // Backpressure: first beat 'hA from ch0, then three stall cycles.
        do_reset();
        mode = 1'b0; fixed_sel = 2'd0; bus4.in_valid = 4'b0011; bus4.in_data = 16'h00BA;
        bus4.out_ready = 1'b1;
        cycle();
        bus4.out_ready = 1'b0; fixed_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(bus4.out_valid), 32'd1);
            chk("bp_data", 32'(bus4.out_data), 32'hA);
            #1;
            chk("bp_in_ready", 32'(bus4.in_ready), 32'd0);
            cycle();
        end
        chk("bp_hold", 32'(bus4.out_data), 32'hA);
        bus4.out_ready = 1'b1;
        cycle();
        chk("bp_next_valid", 32'(bus4.out_valid), 32'd1);
        chk("bp_next_data", 32'(bus4.out_data), 32'hB);
        chk("bp_next_sel", 32'(bus4.out_sel), 32'd1);

        // Reset mid-operation with ptr = 2.
        do_reset();
        mode = 1'b1; bus4.in_valid = 4'hF; bus4.in_data = 16'h4321; bus4.out_ready = 1'b1;
        cycle();
        cycle();
        chk("mid_valid", 32'(bus4.out_valid), 32'd1);
        chk("mid_sel", 32'(bus4.out_sel), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_data", 32'(bus4.out_data), 32'd0);
        chk("rst_sel", 32'(bus4.out_sel), 32'd0);
        #1;
        chk("rst_grant", 32'(bus4.in_ready), 32'b0001);
        cycle();
        chk("rst_first_sel", 32'(bus4.out_sel), 32'd0);
        chk("rst_first_data", 32'(bus4.out_data), 32'h1);

        // Randomized traffic; producers hold valid/data until accepted.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] prev_ready;
            prev_ready = exp_ready;
            rst            = ($urandom_range(0, 49) == 0);
            mode           = 1'($urandom_range(0, 1));
            fixed_sel      = 2'($urandom_range(0, 3));
            bus4.out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) begin
                if (!(bus4.in_valid[c] && !prev_ready[c])) begin
                    bus4.in_valid[c] = 1'($urandom_range(0, 1));
                    bus4.in_data[c*4 +: 4] = 4'($urandom_range(0, 15));
                end
            end
            cycle();
        end

        // N = 3 instance: out-of-range select, then wrap at N-1.
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd3;
        bus3.in_valid = 3'b111; bus3.in_data = 12'h987; bus3.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("n3_oor_ready", 32'(bus3.in_ready), 32'd0);
            @(posedge clk); #1;
            chk("n3_oor_valid", 32'(bus3.out_valid), 32'd0);
        end
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_ready", 32'(bus3.in_ready), 32'b100);
        @(posedge clk); #1;
        chk("n3_sel2_valid", 32'(bus3.out_valid), 32'd1);
        chk("n3_sel2_sel", 32'(bus3.out_sel), 32'd2);
        chk("n3_sel2_data", 32'(bus3.out_data), 32'h9);
        mode3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("n3_rr_ready", 32'(bus3.in_ready), 32'(1 << (k % 3)));
            @(posedge clk); #1;
            chk("n3_rr_sel", 32'(bus3.out_sel), 32'(k % 3));
            chk("n3_rr_data", 32'(bus3.out_data), 32'(7 + (k % 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
